// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction prefetch queue.
// Master is the fetch/decode side; slave is the queue itself.
interface inst_fetch_queue_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_pc;
  logic [DATA_W-1:0] fetch_inst;
  logic              fetch_ready;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [DATA_W-1:0] id_inst;
  logic              id_ready;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, fetch_valid, fetch_pc, fetch_inst, id_ready,
    input  fetch_ready, id_valid, id_pc, id_inst, count
  );

  modport slave (
    input  flush, fetch_valid, fetch_pc, fetch_inst, id_ready,
    output fetch_ready, id_valid, id_pc, id_inst, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Prefetch FIFO of {pc, instruction} pairs between fetch and decode.
// Occupancy alone decides full/empty; an empty head reads as a NOP bubble.
module inst_fetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_fetch_queue_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             not_empty;
  logic             not_full;
  logic             push;
  logic             pop;

  assign not_empty = (count_q != '0);
  assign not_full  = (count_q != CNT_W'(DEPTH));
  assign push      = bus.fetch_valid & not_full;
  assign pop       = not_empty & bus.id_ready;

  // Flush wins over any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      pc_mem[wr_ptr_q]   <= bus.fetch_pc;
      inst_mem[wr_ptr_q] <= bus.fetch_inst;
    end
  end

  assign bus.fetch_ready = not_full;
  assign bus.id_valid    = not_empty;
  assign bus.id_pc       = not_empty ? pc_mem[rd_ptr_q]   : '0;
  assign bus.id_inst     = not_empty ? inst_mem[rd_ptr_q] : '0;
  assign bus.count       = count_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(DEPTH));
  a_bubble_zero: assert property (@(posedge clk) disable iff (!rst_n)
    !not_empty |-> (bus.id_pc == '0 && bus.id_inst == '0));
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench: a queue-based reference model predicts occupancy and pop order;
// a negedge monitor compares DUT outputs and handshakes against the predictions.
module tb_inst_fetch_queue;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } pair_t;

  typedef struct packed {
    logic [CNT_W-1:0]  cnt;
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } state_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pair_t  model[$];
  pair_t  exp_q[$];
  state_t st_q[$];

  inst_fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model across the coming edge.
  task automatic cycle(input logic fv, input logic [ADDR_W-1:0] pc,
                       input logic [DATA_W-1:0] inst, input logic rdy,
                       input logic fl, output logic acc);
    state_t s;
    logic   full;
    @(posedge clk);
    #2;
    bus.fetch_valid = fv;
    bus.fetch_pc    = pc;
    bus.fetch_inst  = inst;
    bus.id_ready    = rdy;
    bus.flush       = fl;
    s.cnt   = CNT_W'(model.size());
    s.valid = (model.size() != 0);
    s.ready = (model.size() != DEPTH);
    s.pc    = (model.size() != 0) ? model[0].pc   : '0;
    s.inst  = (model.size() != 0) ? model[0].inst : '0;
    st_q.push_back(s);
    acc  = 1'b0;
    full = (model.size() == DEPTH);
    if (fl) begin
      model.delete();
    end else begin
      if (rdy && model.size() != 0) exp_q.push_back(model.pop_front());
      if (fv && !full) begin
        model.push_back('{pc: pc, inst: inst});
        acc = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, rdy, 1'b0, a);
  endtask

  // Monitor: per-cycle state checks and pop-order checks on every accepted handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (st_q.size() > 0) begin
        state_t s;
        s = st_q.pop_front();
        chk("count",       64'(bus.count),       64'(s.cnt));
        chk("id_valid",    64'(bus.id_valid),    64'(s.valid));
        chk("fetch_ready", 64'(bus.fetch_ready), 64'(s.ready));
        chk("head_pc",     64'(bus.id_pc),       64'(s.pc));
        chk("head_inst",   64'(bus.id_inst),     64'(s.inst));
      end
      if (bus.id_valid && bus.id_ready && !bus.flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_order actual=pop_of_pc_%0h required=no_pop", bus.id_pc);
        end else begin
          pair_t p;
          p = exp_q.pop_front();
          chk("pop_pc",   64'(bus.id_pc),   64'(p.pc));
          chk("pop_inst", 64'(bus.id_inst), 64'(p.inst));
        end
      end
    end
  end

  initial begin
    logic                a;
    logic [ADDR_W-1:0]   pc;
    bus.flush       = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.fetch_pc    = '0;
    bus.fetch_inst  = '0;
    bus.id_ready    = 1'b0;

    // Reset values while rst_n is held low.
    #2;
    chk("rst_count",       64'(bus.count),       64'd0);
    chk("rst_id_valid",    64'(bus.id_valid),    64'd0);
    chk("rst_id_pc",       64'(bus.id_pc),       64'd0);
    chk("rst_id_inst",     64'(bus.id_inst),     64'd0);
    chk("rst_fetch_ready", 64'(bus.fetch_ready), 64'd1);
    #6 rst_n = 1'b1;

    // Single pass-through.
    cycle(1'b1, 32'h0, 32'h3401_0001, 1'b1, 1'b0, a);
    idle(3, 1'b1);

    // Fill, drop a fifth push, then drain in order.
    for (int i = 0; i < 4; i++) cycle(1'b1, ADDR_W'(4 * i), 32'h2000_0000 + DATA_W'(i), 1'b0, 1'b0, a);
    cycle(1'b1, 32'h10, 32'hDEAD_0010, 1'b0, 1'b0, a);
    idle(6, 1'b1);

    // Hold occupancy at two while streaming ten sequential pcs through.
    cycle(1'b1, 32'h1000, 32'hA000_0000, 1'b0, 1'b0, a);
    cycle(1'b1, 32'h1004, 32'hA000_0001, 1'b0, 1'b0, a);
    for (int i = 2; i < 12; i++) cycle(1'b1, 32'h1000 + ADDR_W'(4 * i), 32'hA000_0000 + DATA_W'(i), 1'b1, 1'b0, a);
    idle(4, 1'b1);

    // Flush with three pending entries and a same-cycle push.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h80 + ADDR_W'(4 * i), 32'hB000_0000 + DATA_W'(i), 1'b0, 1'b0, a);
    cycle(1'b1, 32'h100, 32'hC000_0100, 1'b1, 1'b1, a);
    cycle(1'b1, 32'h200, 32'hC000_0200, 1'b0, 1'b0, a);
    idle(3, 1'b1);

    // Asynchronous reset between edges with three entries queued.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h300 + ADDR_W'(4 * i), 32'hD000_0000 + DATA_W'(i), 1'b0, 1'b0, a);
    @(posedge clk);
    #2;
    bus.fetch_valid = 1'b0;
    bus.id_ready    = 1'b0;
    rst_n = 1'b0;
    model.delete();
    exp_q.delete();
    st_q.delete();
    #1;
    chk("async_rst_count",       64'(bus.count),       64'd0);
    chk("async_rst_id_valid",    64'(bus.id_valid),    64'd0);
    chk("async_rst_id_inst",     64'(bus.id_inst),     64'd0);
    chk("async_rst_fetch_ready", 64'(bus.fetch_ready), 64'd1);
    #6 rst_n = 1'b1;
    cycle(1'b1, 32'h400, 32'hE000_0400, 1'b1, 1'b0, a);
    idle(3, 1'b1);

    // Randomized traffic with a stalling fetch and occasional flushes.
    pc = 32'h8000;
    for (int i = 0; i < 400; i++) begin
      logic fv, rdy, fl;
      fv  = ($urandom_range(3) != 0);
      rdy = ($urandom_range(2) != 0);
      fl  = ($urandom_range(15) == 0);
      cycle(fv, pc, $urandom, rdy, fl, a);
      if (a) pc = pc + 32'd4;
    end
    idle(DEPTH + 3, 1'b1);

    @(posedge clk);
    #2;
    chk("scoreboard_pops_left",   64'(exp_q.size()), 64'd0);
    chk("scoreboard_states_left", 64'(st_q.size()),  64'd0);
    chk("model_entries_left",     64'(model.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Prefetch queue between the PC/instruction-memory fetch stage and the decode stage of the MIPS pipeline. Captures each fetched {pc, instruction} pair into a small FIFO. Presents the oldest pair to decode with a valid/ready handshake, and back-pressures fetch when full. Flush discards all queued and in-flight fetches on branch/jump redirect.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2
ADDR_W, 32, instruction address width (matches the InstAddrBus width)
DATA_W, 32, instruction word width

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
flush  input  1  discard all entries; from branch/jump resolution
fetch_valid  input  1  fetch presents a valid pair (the instruction-memory enable gated with memory data ready)
fetch_pc  input  ADDR_W  address of the fetched instruction
fetch_inst  input  DATA_W  fetched instruction word
fetch_ready  output  1  queue can accept a push this cycle
id_valid  output  1  head entry valid for decode
id_pc  output  ADDR_W  head entry address
id_inst  output  DATA_W  head entry instruction
id_ready  input  1  decode consumes head this cycle
count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0.
  - Outputs while reset is asserted: id_valid=0, id_pc=0, id_inst=0, fetch_ready=1.
  - Storage contents are don't-care.
  - Release is taken synchronously at the next clk edge.
- Push: push = fetch_valid & fetch_ready.
  - On the edge, writes {fetch_pc, fetch_inst} at wr_ptr and advances wr_ptr modulo DEPTH.
- Pop: pop = id_valid & id_ready; advances rd_ptr modulo DEPTH on the edge.
- count: next = count + push - pop. Push and pop in the same cycle leave count unchanged.
- fetch_ready = (count != DEPTH). Purely a function of registered count; no combinational path from id_ready.
  - When full, the queue does not accept a push even if a pop occurs that cycle.
- fetch_valid while fetch_ready=0: pair is dropped. Fetch must hold its PC (stall) when it sees fetch_ready=0.
- Head presentation: combinational read of entry rd_ptr.
  - id_valid = (count != 0).
  - When count==0, id_pc and id_inst are forced to 0, so decode sees a NOP bubble (0x00000000 = sll $0,$0,0).
- Latency: a pair pushed at edge N is visible on id_* after edge N. Minimum 1 cycle fetch-to-decode; no bypass when empty.
- Flush (synchronous, highest priority after reset):
  - On an edge with flush=1: wr_ptr=rd_ptr=0, count=0.
  - Same-cycle push and pop are both ignored; the pair presented with flush is lost.
  - In the cycle after flush: id_valid=0 and fetch_ready=1.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. Full/empty are decided by count only, never by pointer equality.
- Ordering: strict FIFO; pairs leave in push order; no reordering or duplication.
- Reset mid-operation: asynchronous clear as above; in-progress pushes/pops are abandoned.
- Assertions for verification:
  - count never exceeds DEPTH.
  - id_valid==0 implies id_pc==0 and id_inst==0.
  - No push when fetch_ready==0.

Test Plan:
1. Reset and single pass-through:
   - Release rst_n; push pc=0x0, inst=0x34010001 with id_ready=1.
   - Next cycle: id_valid=1, id_pc=0x0, id_inst=0x34010001, count=1.
   - Following cycle: count=0, id_valid=0, id_inst=0.
2. Fill and back-pressure:
   - id_ready=0; push pc=0x0,0x4,0x8,0xC.
   - Required: count=4, fetch_ready=0.
   - A fifth push of pc=0x10 is dropped.
   - Then id_ready=1: decode receives 0x0,0x4,0x8,0xC in order, and fetch_ready returns to 1 after the first pop.
3. Simultaneous push/pop with wrap-around:
   - Hold count=2 and stream 10 sequential pcs with fetch_valid=id_ready=1.
   - Required: count stays 2 throughout; pointers wrap past DEPTH-1; output pcs strictly sequential, none missing.
4. Flush with pending entries and same-cycle push:
   - count=3; assert flush with fetch_valid=1, pc=0x100.
   - Next cycle: count=0, id_valid=0, fetch_ready=1.
   - Next push, pc=0x200, appears at head with no stale entries before it.
5. Asynchronous reset mid-stream:
   - count=3; drive rst_n low between clock edges.
   - id_valid=0 and count=0 immediately, without waiting for clk.
   - After release, the first push is returned correctly.
